// File: rtl/pkg_seg7.sv
// rtl/pkg_seg7.sv - segment codes and BCD decode function for the 7-segment scanner
package pkg_seg7;

    localparam int C_NUM_DIGITS = 6;

    // Active-low patterns, bit 0 = segment a .. bit 6 = segment g
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    function automatic logic [6:0] f_bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/m_bcd_to_seg7.sv
// rtl/m_bcd_to_seg7.sv - combinational BCD nibble to active-low 7-segment decoder
module m_bcd_to_seg7
    import pkg_seg7::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = f_bcd_to_seg(bcd);

endmodule

// File: rtl/m_seg7_scan.sv
// rtl/m_seg7_scan.sv - 6-digit multiplexed 7-segment scanner with per-frame snapshot
module m_seg7_scan
    import pkg_seg7::*;
#(
    parameter int P_SCAN_DIV = 10000,
    parameter int P_BLANK    = 100,
    parameter int P_LZB      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    input  logic [7:0] msec,
    output logic [7:0] seg_n,
    output logic [5:0] dig_n,
    output logic       frame_start
);

    localparam int CW = (P_SCAN_DIV > 1) ? $clog2(P_SCAN_DIV) : 1;
    localparam logic [2:0] LAST_IDX = 3'(C_NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [23:0]   snapshot;

    logic          slot_end;
    logic          frame_end;
    logic          blank;
    logic [3:0]    nib;
    logic [6:0]    seg_code;
    logic          dp_n;
    logic          lzb_hit;
    logic [5:0]    dig_nxt;
    logic [7:0]    seg_nxt;

    assign slot_end  = (cnt == CW'(P_SCAN_DIV - 1));
    assign frame_end = slot_end && (idx == LAST_IDX);
    assign blank     = (int'(cnt) < P_BLANK);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            snapshot    <= '0;
            frame_start <= 1'b0;
            dig_n       <= 6'h3F;
            seg_n       <= 8'hFF;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
            end
            // Loading only at the frame boundary keeps all six digits from one instant
            if (frame_end) begin
                snapshot <= {min, sec, msec};
            end
            frame_start <= frame_end;
            dig_n       <= dig_nxt;
            seg_n       <= seg_nxt;
        end
    end

    always_comb begin
        nib = snapshot[3:0];
        case (idx)
            3'd1:    nib = snapshot[7:4];
            3'd2:    nib = snapshot[11:8];
            3'd3:    nib = snapshot[15:12];
            3'd4:    nib = snapshot[19:16];
            3'd5:    nib = snapshot[23:20];
            default: nib = snapshot[3:0];
        endcase
    end

    m_bcd_to_seg7 u_dec (
        .bcd (nib),
        .seg (seg_code)
    );

    // Decimal points after the minutes and seconds ones digits: mm.ss.hh
    assign dp_n    = !((idx == 3'd2) || (idx == 3'd4));
    assign lzb_hit = (P_LZB != 0) && (idx == LAST_IDX) && (snapshot[23:20] == 4'd0);

    always_comb begin
        dig_nxt = 6'h3F;
        seg_nxt = {1'b1, SEG_OFF};
        if (!blank) begin
            dig_nxt = ~(6'd1 << idx);
            seg_nxt = {dp_n, seg_code};
            if (lzb_hit) begin
                seg_nxt = {1'b1, SEG_OFF};
            end
        end
    end

endmodule
